mem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 64 KiB byte-addressed backing memory. It accepts whole-word read/write requests from two clients, typically the instruction-side and data-side cache controllers. It issues each request to the memory's req/rw/rdy handshake and waits for the multi-cycle byte-serial transfer to finish. It then returns completion, read data and a timeout error to the owning client.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer that lets two word clients
// share one byte-serial 64 KiB memory behind a req/rw/rdy handshake.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rN_req/rw/addr/wdata        client N request (level, held until done)
//   rN_rdata/done/err           client N read word, done pulse, timeout flag
//   mem_req/rw/addr/wdata       request strobe and operands to memory
//   mem_rdata/rdy               read word and completion pulse from memory
//   busy, owner                 transaction in flight, current/last grant
module mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_rw,
    input  logic [15:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic [31:0] r0_rdata,
    output logic        r0_done,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_rw,
    input  logic [15:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic [31:0] r1_rdata,
    output logic        r1_done,
    output logic        r1_err,
    output logic        mem_req,
    output logic        mem_rw,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant;
    logic             any_req;
    logic             timed_out;
    logic             finish;
    logic [31:0]      rd_word;
    logic             unused_addr_lsbs;

    // Word-aligned addressing: the byte offset bits are deliberately dropped.
    assign unused_addr_lsbs = ^{r0_addr[1:0], r1_addr[1:0]};

    // Owner and last grant are the same register: it only moves on a grant.
    assign owner = last_grant;

    always_comb begin
        any_req = r0_req | r1_req;
        // On a tie the client that did not win last time goes next.
        grant = (r0_req && r1_req) ? ~last_grant : r1_req;
        // A ready on the final wait cycle still counts as success.
        timed_out = !mem_rdy && (cnt == CNT_LAST);
        finish = mem_rdy || timed_out;
        rd_word = mem_rdy ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= 16'h0;
            mem_wdata  <= 32'h0;
            r0_done    <= 1'b0;
            r0_err     <= 1'b0;
            r0_rdata   <= 32'h0;
            r1_done    <= 1'b0;
            r1_err     <= 1'b0;
            r1_rdata   <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        mem_req    <= 1'b1;
                        last_grant <= grant;
                        if (grant) begin
                            mem_rw    <= r1_rw;
                            mem_addr  <= {r1_addr[15:2], 2'b00};
                            mem_wdata <= r1_wdata;
                        end else begin
                            mem_rw    <= r0_rw;
                            mem_addr  <= {r0_addr[15:2], 2'b00};
                            mem_wdata <= r0_wdata;
                        end
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    mem_req <= 1'b0;
                    cnt     <= '0;
                end
                WAIT: begin
                    if (finish) begin
                        state <= DONE;
                        if (last_grant) begin
                            r1_done <= 1'b1;
                            r1_err  <= timed_out;
                            if (!mem_rw) r1_rdata <= rd_word;
                        end else begin
                            r0_done <= 1'b1;
                            r0_err  <= timed_out;
                            if (!mem_rw) r0_rdata <= rd_word;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    r0_done <= 1'b0;
                    r0_err  <= 1'b0;
                    r1_done <= 1'b0;
                    r1_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-
// programmable memory responder and an expected-transaction queue.
module tb_mem_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        r0_req, r0_rw, r1_req, r1_rw;
    logic [15:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_done, r0_err, r1_done, r1_err;
    logic        mem_req, mem_rw, mem_rdy;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy, owner;

    mem_arbiter #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rdata(r0_rdata),
        .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rdata(r1_rdata),
        .r1_done(r1_done), .r1_err(r1_err),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rdy(mem_rdy), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        c;
        logic        rw;
        logic [15:0] maddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        me;
    logic [31:0] mem[int];
    logic [31:0] ref_mem[int];
    logic [31:0] exp_last[2];
    logic [31:0] done_last[2];
    int          lat;
    int          n_chk, n_fail, n_done;
    int          cyc, issue_cyc, last_done;
    logic        prev_req, b2b_on;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a, ~a};
    endfunction

    function automatic logic [31:0] mrd(input logic [15:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : pat(a);
    endfunction

    function automatic logic [31:0] rrd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
    endfunction

    task automatic push(input logic c, input logic rw,
                        input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        e.c     = c;
        e.rw    = rw;
        e.maddr = {a[15:2], 2'b00};
        e.wdata = d;
        e.err   = (lat == 0);
        e.gap   = (lat == 0) ? TO + 1 : lat + 1;
        if (rw) begin
            if (!e.err) ref_mem[int'(e.maddr)] = d;
            e.rdata = exp_last[c];
        end else begin
            e.rdata = e.err ? 32'h0 : rrd(e.maddr);
        end
        exp_last[c] = e.rdata;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic c, input logic rw,
                         input logic [15:0] a, input logic [31:0] d);
        if (c) begin
            r1_rw = rw; r1_addr = a; r1_wdata = d; r1_req = 1'b1;
        end else begin
            r0_rw = rw; r0_addr = a; r0_wdata = d; r0_req = 1'b1;
        end
    endtask

    task automatic start(input logic c, input logic rw,
                         input logic [15:0] a, input logic [31:0] d);
        push(c, rw, a, d);
        drive(c, rw, a, d);
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("wait_done", n_done, target);
    endtask

    task automatic chk_reset();
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_done", {r1_done, r0_done}, 0);
        chk("rst_err", {r1_err, r0_err}, 0);
        chk("rst_r0_rdata", r0_rdata, 0);
        chk("rst_r1_rdata", r1_rdata, 0);
        chk("rst_owner", owner, 1);
        chk("rst_busy", busy, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_last  = '{32'h0, 32'h0};
        done_last = '{32'h0, 32'h0};
        b2b_on = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset();
    endtask

    // Memory responder: rdy is sampled lat edges after the memory sees req.
    initial begin
        int          l;
        logic        rw;
        logic [15:0] a;
        logic [31:0] d;
        mem_rdy   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                l = lat; rw = mem_rw; a = mem_addr; d = mem_wdata;
                if (l > 0) begin
                    repeat (l) @(posedge clk);
                    #1;
                    mem_rdy = 1'b1;
                    if (rw) begin
                        mem[int'(a)] = d;
                        mem_rdata = 32'hdeadbeef;
                    end else begin
                        mem_rdata = mrd(a);
                    end
                    @(posedge clk);
                    #1;
                    mem_rdy   = 1'b0;
                    mem_rdata = 32'h0;
                end
            end
        end
    end

    // Monitor: checks issue, hold and completion against the queue head.
    initial begin
        cyc = 0; issue_cyc = 0; last_done = 0; prev_req = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                chk("req_pulse", prev_req, 0);
                if (exp_q.size() == 0) begin
                    chk("unexp_issue", mem_req, 0);
                end else begin
                    chk("owner", owner, exp_q[0].c);
                    chk("busy", busy, 1);
                    chk("mem_rw", mem_rw, exp_q[0].rw);
                    chk("mem_addr", mem_addr, exp_q[0].maddr);
                    chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                    issue_cyc = cyc;
                    if (b2b_on) chk("idle_gap", cyc - last_done, 2);
                end
            end else if (busy && !r0_done && !r1_done && exp_q.size() > 0) begin
                chk("hold_rw", mem_rw, exp_q[0].rw);
                chk("hold_addr", mem_addr, exp_q[0].maddr);
                chk("hold_wdata", mem_wdata, exp_q[0].wdata);
            end
            if (r0_done || r1_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_done", {r1_done, r0_done}, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("done_sel", {r1_done, r0_done},
                        me.c ? 2'b10 : 2'b01);
                    chk("err", me.c ? r1_err : r0_err, me.err);
                    chk("err_other", me.c ? r0_err : r1_err, 0);
                    chk("rdata", me.c ? r1_rdata : r0_rdata, me.rdata);
                    chk("rdata_other", me.c ? r0_rdata : r1_rdata,
                        done_last[!me.c]);
                    chk("latency", cyc - issue_cyc, me.gap);
                    done_last[me.c] = me.rdata;
                    last_done = cyc;
                    n_done++;
                end
            end
            prev_req = mem_req;
        end
    end

    initial begin
        int base;
        n_chk = 0; n_fail = 0; n_done = 0;
        rst = 1'b1; lat = 3; b2b_on = 1'b0;
        r0_req = 0; r0_rw = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_rw = 0; r1_addr = 0; r1_wdata = 0;
        exp_last  = '{32'h0, 32'h0};
        done_last = '{32'h0, 32'h0};
        mem[0]     = 32'hefefefef;
        ref_mem[0] = 32'hefefefef;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset();

        // r0 read of an unaligned address
        @(posedge clk);
        #1;
        lat = 3;
        start(1'b0, 1'b0, 16'h0002, 32'h0);
        wait_done(1);
        r0_req = 1'b0;

        // r1 write; memory returns junk that must not reach r1_rdata
        lat = 4;
        start(1'b1, 1'b1, 16'h1234, 32'h12345678);
        wait_done(2);
        r1_req = 1'b0;

        // both clients held from reset: r0, r1, r0, r1 back to back
        apply_reset();
        @(posedge clk);
        #1;
        lat = 2;
        base = n_done;
        push(1'b0, 1'b0, 16'h0100, 32'h0);
        push(1'b1, 1'b1, 16'h0200, 32'ha5a50f0f);
        push(1'b0, 1'b0, 16'h0100, 32'h0);
        push(1'b1, 1'b1, 16'h0200, 32'ha5a50f0f);
        drive(1'b0, 1'b0, 16'h0100, 32'h0);
        drive(1'b1, 1'b1, 16'h0200, 32'ha5a50f0f);
        wait_done(base + 1);
        b2b_on = 1'b1;
        wait_done(base + 4);
        r0_req = 1'b0;
        r1_req = 1'b0;
        b2b_on = 1'b0;

        // memory never answers: timeout after TIMEOUT+1 cycles
        lat = 0;
        start(1'b0, 1'b0, 16'h0040, 32'h0);
        wait_done(n_done + 1);
        r0_req = 1'b0;

        // ready on the very last wait cycle beats the timeout
        lat = TO;
        start(1'b1, 1'b0, 16'h0106, 32'h0);
        wait_done(n_done + 1);
        r1_req = 1'b0;

        // stray ready while idle is ignored
        mem_rdy   = 1'b1;
        mem_rdata = 32'h55aa55aa;
        @(posedge clk);
        #1;
        mem_rdy   = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_done", {r1_done, r0_done}, 0);
        chk("stray_mem_req", mem_req, 0);
        chk("stray_r1_rdata", r1_rdata, done_last[1]);

        // reset in the middle of WAIT aborts silently
        @(posedge clk);
        #1;
        lat = 0;
        start(1'b0, 1'b0, 16'h0080, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        r0_req = 1'b0;
        apply_reset();

        // r1-only request served normally afterwards
        @(posedge clk);
        #1;
        lat = 2;
        start(1'b1, 1'b0, 16'h0300, 32'h0);
        wait_done(n_done + 1);
        r1_req = 1'b0;

        repeat (4) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
